lfsr_gen: RTL

//  Parametrised pseudo-random sequence generator; generalises the fixed 4-bit LFSR to any width/polynomial.

---
 rtl/lfsr_gen_if.sv | 11 +
 rtl/lfsr_gen.sv | 83 ++++++++
 2 files changed

// File: rtl/lfsr_gen_if.sv
// Output stream of the LFSR generator: state beat plus valid/ready handshake.
interface lfsr_gen_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input  out_ready);
  modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, valid/ready output stream
// and period measurement between successive returns to the active seed.
module lfsr_gen #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1010,
  parameter int unsigned      MODE  = 0,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  lfsr_gen_if.master       stream,
  output logic             wrap,
  output logic [WIDTH-1:0] period_len,
  output logic             seed_err
);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t             fsm, fsm_next;
  logic [WIDTH-1:0] lfsr, seed, nxt, step_cnt, cnt_inc, load_val;
  logic             accept, load_zero;

  always_comb begin
    nxt = '0;
    if (MODE == 0) nxt = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    else           nxt = {lfsr[WIDTH-2:0], 1'b0} ^ ({WIDTH{lfsr[WIDTH-1]}} & TAPS);
  end

  assign stream.out_data  = lfsr;
  assign stream.out_valid = (fsm == RUN);

  // A same-cycle load wins over the handshake, so that beat is not consumed.
  assign accept    = stream.out_valid && stream.out_ready && !load;
  assign load_zero = (load_data == '0);
  assign load_val  = load_zero ? SEED : load_data;
  assign cnt_inc   = (step_cnt == '1) ? step_cnt : step_cnt + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_next;
  end

  // Leaving RUN waits for any outstanding beat to be taken.
  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE: if (enable) fsm_next = RUN;
      RUN:  if (!enable && stream.out_ready) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr       <= SEED;
      seed       <= SEED;
      step_cnt   <= '0;
      period_len <= '0;
      wrap       <= 1'b0;
      seed_err   <= 1'b0;
    end else begin
      wrap     <= accept && (nxt == seed);
      seed_err <= load && load_zero;
      if (load) begin
        lfsr     <= load_val;
        seed     <= load_val;
        step_cnt <= '0;
      end else if (accept) begin
        lfsr <= nxt;
        if (nxt == seed) begin
          period_len <= cnt_inc;
          step_cnt   <= '0;
        end else begin
          step_cnt   <= cnt_inc;
        end
      end
    end
  end

endmodule
